memio_bridge: RTL and testbench
===============================

Name: memio_bridge

Overview:
- Parametrised, sequential successor to the combinational memory/IO select unit of the Minisys-1A CPU.
- Sits between the CPU MEM stage and both data RAM and the IO peripheral bus.
- Decodes NUM_IO IO channels from a base/stride window and applies Memory_data_width/Memory_sign (byte lanes, alignment check, sign/zero extension).
- Runs a handshake FSM with per-channel IO_ready, wait-state stall, timeout and bus-error reporting.

Parameters:
NUM_IO, 8, number of IO channels (1..16)
IO_BASE, 32'hFFFFFC00, address of channel 0
IO_STRIDE, 16, byte spacing between channels (power of 2)
IO_DATA_W, 16, IO data width (8..32)
TIMEOUT, 15, max wait cycles for IO_ready before error (counter width $clog2(TIMEOUT+1))

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
Address  in  32  byte address from ALU
Memory_read, Memory_write, IO_read, IO_write  in  1 each  CPU strobes, held until Stall low
Memory_sign  in  1  1 = sign-extend reads
Memory_data_width  in  2  00 byte, 01 half, 10 word, 11 illegal
Write_data_in  in  32  store data (right-justified)
Memory_read_data  in  32  RAM read word, valid cycle after Memory_enable
Memory_enable  out  1  RAM access strobe
Memory_byte_en  out  4  RAM write lane enables (0 on reads)
Memory_write_data  out  32  lane-replicated store data
IO_read_data  in  NUM_IO*IO_DATA_W  channel k at slice [k*IO_DATA_W +: IO_DATA_W]
IO_ready  in  NUM_IO  per-channel completion
IO_sel  out  NUM_IO  one-hot channel select
IO_rd, IO_wr  out  1 each  IO direction strobes
IO_write_data  out  IO_DATA_W  low IO_DATA_W bits of latched store data
Read_data  out  32  registered load result
Stall  out  1  hold CPU pipeline
Bus_error  out  1  one-cycle error pulse

Behaviour:
- Reset (reset=0, any time): state IDLE, every output 0, timeout counter 0, latches cleared; an in-flight access is aborted with no completion.
- States: IDLE, MEM, IO, DONE, ERR.
- IDLE, any strobe high:
  - latch Address, width, sign, Write_data_in and op;
  - Stall=1 combinationally;
  - select next state by the rules below.
- Illegal requests go to ERR:
  - more than one strobe high;
  - width=11;
  - half with A[0]=1;
  - word with A[1:0]!=0.
- Memory op -> MEM:
  - Memory_enable=1 for exactly the MEM cycle;
  - Memory_byte_en: byte 1<<A[1:0], half 0011/1100 by A[1], word 1111 (writes only).
- IO op:
  - channel k = (A-IO_BASE)/IO_STRIDE;
  - valid iff A-IO_BASE is a multiple of IO_STRIDE and k<NUM_IO; invalid -> ERR; valid -> IO.
- IO state:
  - IO_sel[k], IO_rd/IO_wr and IO_write_data held constant;
  - counter increments each cycle;
  - IO_ready[k]=1 -> DONE, capturing IO data the same edge;
  - counter==TIMEOUT without ready -> ERR;
  - IO_ready of unselected channels ignored;
  - ready in first IO cycle gives zero wait states.
- MEM -> DONE unconditionally; load data captured at the MEM->DONE edge.
- DONE:
  - Stall=0, Read_data valid (loads; stores leave Read_data unchanged);
  - IO_sel, IO_rd, IO_wr, Memory_enable all 0;
  - next state IDLE.
- ERR:
  - Stall=0, Bus_error=1, Read_data=0;
  - next state IDLE.
- Load formatting:
  - memory: lane selected by A[1:0];
  - byte/half extension per Memory_sign;
  - IO: IO_DATA_W value zero-extended, or sign-extended from bit IO_DATA_W-1 when Memory_sign=1.
- Store replication: byte {4{d[7:0]}}, half {2{d[15:0]}}, word d.
- Latency:
  - memory access: Stall high 2 cycles, result in 3rd;
  - IO access: 2+wait cycles.
- Strobes seen in DONE/ERR are ignored; CPU must re-present them in IDLE. Back-to-back accesses are therefore separated by one idle cycle.

Decomposition:
- Package memio_pkg: state enum, width codes (W_BYTE/W_HALF/W_WORD), default IO_BASE/IO_STRIDE constants.
- One sub-module memio_lane_fmt: pure combinational load extract/extend and store replicate/byte-enable. It is shared by the MEM and IO paths.

Test Plan:
- Word store 0x12345678 to 0x100, then lb signed at 0x103 -> byte_en 1111, Stall 2 cycles; Read_data 0x00000012. lh signed at 0x102 with RAM word 0x80FF0000 -> 0xFFFF80FF.
- sb 0xAB at 0x101 -> Memory_byte_en 0010, Memory_write_data 0xABABABAB.
- IO_read at 0xFFFFFC30, IO_ready[3] after 4 cycles, data 0x8001, sign=0 -> IO_sel 0x08 held 4 cycles; Read_data 0x00008001. Same with sign=1 -> 0xFFFF8001.
- IO_write at 0xFFFFFC50, ready never asserted -> Bus_error pulse after TIMEOUT+1 IO cycles, Read_data 0, FSM back to IDLE.
- Illegal requests: lw at 0x102, IO access at 0xFFFFFC04, IO access at 0xFFFFFC80, Memory_read+IO_read together -> each gives ERR the cycle after request, no Memory_enable/IO_sel asserted.
- reset deasserted→asserted low during IO wait -> all outputs 0 immediately; after release a fresh lw completes normally.

Source files
------------

// File: rtl/memio_pkg.sv
// Shared types and constants for the memory/IO bridge between the CPU MEM stage,
// data RAM and the IO peripheral bus.
package memio_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MEM,
        S_IO,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [1:0] W_BYTE    = 2'b00;
    localparam logic [1:0] W_HALF    = 2'b01;
    localparam logic [1:0] W_WORD    = 2'b10;
    localparam logic [1:0] W_ILLEGAL = 2'b11;

    localparam logic [31:0] DEF_IO_BASE   = 32'hFFFFFC00;
    localparam int          DEF_IO_STRIDE = 16;

    // Natural alignment of an access of the given width at byte offset a.
    function automatic logic aligned(input logic [1:0] width, input logic [1:0] a);
        case (width)
            W_BYTE:    aligned = 1'b1;
            W_HALF:    aligned = ~a[0];
            W_WORD:    aligned = (a == 2'b00);
            W_ILLEGAL: aligned = 1'b0;
            default:   aligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/memio_lane_fmt.sv
// Byte-lane formatting shared by the RAM and IO paths: store replication and
// lane enables, plus load lane extraction with zero/sign extension.
module memio_lane_fmt
    import memio_pkg::*;
#(
    parameter int IO_DATA_W = 16
) (
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  width,
    input  logic        sign_ext,
    input  logic        io_path,
    input  logic [31:0] store_data,
    input  logic [31:0] load_raw,
    output logic [3:0]  byte_en,
    output logic [31:0] store_word,
    output logic [31:0] load_word
);

    localparam int IO_SHIFT = 32 - IO_DATA_W;

    logic [7:0]         lane_b;
    logic [15:0]        lane_h;
    logic [31:0]        io_left;
    logic [31:0]        io_zext;
    logic signed [31:0] io_sext;

    always_comb begin
        byte_en    = 4'b0000;
        store_word = store_data;
        case (width)
            W_BYTE: begin
                byte_en    = 4'b0001 << addr_lo;
                store_word = {4{store_data[7:0]}};
            end
            W_HALF: begin
                byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
                store_word = {2{store_data[15:0]}};
            end
            W_WORD:  byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
    end

    // IO values are extended from their own width, independent of the access width.
    always_comb begin
        case (addr_lo)
            2'd0:    lane_b = load_raw[7:0];
            2'd1:    lane_b = load_raw[15:8];
            2'd2:    lane_b = load_raw[23:16];
            default: lane_b = load_raw[31:24];
        endcase
        lane_h  = addr_lo[1] ? load_raw[31:16] : load_raw[15:0];
        io_left = load_raw << IO_SHIFT;
        io_zext = io_left >> IO_SHIFT;
        io_sext = $signed(io_left) >>> IO_SHIFT;
        if (io_path) begin
            load_word = sign_ext ? io_sext : io_zext;
        end else begin
            case (width)
                W_BYTE:  load_word = {{24{sign_ext & lane_b[7]}}, lane_b};
                W_HALF:  load_word = {{16{sign_ext & lane_h[15]}}, lane_h};
                default: load_word = load_raw;
            endcase
        end
    end

endmodule

// File: rtl/memio_bridge.sv
// Sequential memory/IO select unit: decodes RAM vs IO channel accesses, runs the
// handshake FSM with wait states, timeout and bus-error reporting.
module memio_bridge
    import memio_pkg::*;
#(
    parameter int          NUM_IO    = 8,
    parameter logic [31:0] IO_BASE   = DEF_IO_BASE,
    parameter int          IO_STRIDE = DEF_IO_STRIDE,
    parameter int          IO_DATA_W = 16,
    parameter int          TIMEOUT   = 15
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [31:0]                 Address,
    input  logic                        Memory_read,
    input  logic                        Memory_write,
    input  logic                        IO_read,
    input  logic                        IO_write,
    input  logic                        Memory_sign,
    input  logic [1:0]                  Memory_data_width,
    input  logic [31:0]                 Write_data_in,
    input  logic [31:0]                 Memory_read_data,
    output logic                        Memory_enable,
    output logic [3:0]                  Memory_byte_en,
    output logic [31:0]                 Memory_write_data,
    input  logic [NUM_IO*IO_DATA_W-1:0] IO_read_data,
    input  logic [NUM_IO-1:0]           IO_ready,
    output logic [NUM_IO-1:0]           IO_sel,
    output logic                        IO_rd,
    output logic                        IO_wr,
    output logic [IO_DATA_W-1:0]        IO_write_data,
    output logic [31:0]                 Read_data,
    output logic                        Stall,
    output logic                        Bus_error
);

    localparam int              CH_W        = (NUM_IO > 1) ? $clog2(NUM_IO) : 1;
    localparam int              CNT_W       = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(TIMEOUT);
    localparam int              STRIDE_SH   = $clog2(IO_STRIDE);
    localparam logic [31:0]     STRIDE_MASK = 32'(IO_STRIDE - 1);

    state_t                 state;
    logic [1:0]             addr_lo_q;
    logic [1:0]             width_q;
    logic                   sign_q;
    logic                   io_q;
    logic                   wr_q;
    logic [31:0]            wdata_q;
    logic [CH_W-1:0]        chan_q;
    logic [CNT_W-1:0]       cnt_q;

    logic [3:0]             strobes;
    logic                   any_strobe;
    logic                   multi_strobe;
    logic                   io_req;
    logic [31:0]            io_offset;
    logic [31:0]            io_index;
    logic                   chan_ok;
    logic                   req_bad;
    logic [CH_W-1:0]        chan_dec;
    logic [IO_DATA_W-1:0]   io_word;
    logic [31:0]            load_raw;
    logic [3:0]             fmt_be;
    logic [31:0]            fmt_store;
    logic [31:0]            fmt_load;

    // Request decode works on the live CPU inputs; it only matters in IDLE.
    assign strobes      = {Memory_read, Memory_write, IO_read, IO_write};
    assign any_strobe   = |strobes;
    assign multi_strobe = (strobes & (strobes - 4'd1)) != 4'd0;
    assign io_req       = IO_read | IO_write;
    assign io_offset    = Address - IO_BASE;
    assign io_index     = io_offset >> STRIDE_SH;
    assign chan_ok      = ((io_offset & STRIDE_MASK) == 32'd0) && (io_index < 32'(NUM_IO));
    assign chan_dec     = io_index[CH_W-1:0];
    assign req_bad      = multi_strobe || !aligned(Memory_data_width, Address[1:0])
                          || (io_req && !chan_ok);

    assign io_word  = IO_read_data[chan_q*IO_DATA_W +: IO_DATA_W];
    assign load_raw = io_q ? 32'(io_word) : Memory_read_data;

    memio_lane_fmt #(.IO_DATA_W(IO_DATA_W)) u_fmt (
        .addr_lo    (addr_lo_q),
        .width      (width_q),
        .sign_ext   (sign_q),
        .io_path    (io_q),
        .store_data (wdata_q),
        .load_raw   (load_raw),
        .byte_en    (fmt_be),
        .store_word (fmt_store),
        .load_word  (fmt_load)
    );

    assign Memory_byte_en    = (Memory_enable && wr_q) ? fmt_be : 4'b0000;
    assign Memory_write_data = fmt_store;
    assign IO_write_data     = wdata_q[IO_DATA_W-1:0];
    // Stall rises in the request cycle itself, but never while held in reset.
    assign Stall = reset && ((state == S_IDLE && any_strobe) || state == S_MEM || state == S_IO);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            addr_lo_q     <= '0;
            width_q       <= '0;
            sign_q        <= 1'b0;
            io_q          <= 1'b0;
            wr_q          <= 1'b0;
            wdata_q       <= '0;
            chan_q        <= '0;
            cnt_q         <= '0;
            Memory_enable <= 1'b0;
            IO_sel        <= '0;
            IO_rd         <= 1'b0;
            IO_wr         <= 1'b0;
            Read_data     <= '0;
            Bus_error     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_strobe) begin
                        addr_lo_q <= Address[1:0];
                        width_q   <= Memory_data_width;
                        sign_q    <= Memory_sign;
                        io_q      <= io_req;
                        wr_q      <= Memory_write | IO_write;
                        wdata_q   <= Write_data_in;
                        cnt_q     <= '0;
                        if (req_bad) begin
                            state     <= S_ERR;
                            Bus_error <= 1'b1;
                            Read_data <= '0;
                        end else if (io_req) begin
                            state  <= S_IO;
                            chan_q <= chan_dec;
                            IO_sel <= NUM_IO'(1) << chan_dec;
                            IO_rd  <= IO_read;
                            IO_wr  <= IO_write;
                        end else begin
                            state         <= S_MEM;
                            Memory_enable <= 1'b1;
                        end
                    end
                end
                S_MEM: begin
                    Memory_enable <= 1'b0;
                    state         <= S_DONE;
                    if (!wr_q) Read_data <= fmt_load;
                end
                // Ready is checked before the timeout so a last-cycle ready still completes.
                S_IO: begin
                    if (IO_ready[chan_q]) begin
                        IO_sel <= '0;
                        IO_rd  <= 1'b0;
                        IO_wr  <= 1'b0;
                        state  <= S_DONE;
                        if (!wr_q) Read_data <= fmt_load;
                    end else if (cnt_q == CNT_MAX) begin
                        IO_sel    <= '0;
                        IO_rd     <= 1'b0;
                        IO_wr     <= 1'b0;
                        state     <= S_ERR;
                        Bus_error <= 1'b1;
                        Read_data <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DONE: state <= S_IDLE;
                S_ERR: begin
                    Bus_error <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memio_bridge.sv
// Randomized bench for memio_bridge: a transaction-level model predicts the
// outputs of every cycle, and a single compare process checks them at negedge.
module tb_memio_bridge;

    localparam int          NUM_IO    = 8;
    localparam logic [31:0] IO_BASE   = 32'hFFFFFC00;
    localparam int          IO_STRIDE = 16;
    localparam int          IO_DATA_W = 16;
    localparam int          TIMEOUT   = 15;
    localparam logic [3:0]  MR = 4'b1000, MW = 4'b0100, IR = 4'b0010, IW = 4'b0001;
    localparam int          NEVER = 1000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] address = '0;
    logic        mem_read = 1'b0, mem_write = 1'b0, io_read = 1'b0, io_write = 1'b0;
    logic        mem_sign = 1'b0;
    logic [1:0]  mem_width = 2'b00;
    logic [31:0] wdata_in = '0;
    logic [31:0] mem_rdata;
    logic [NUM_IO*IO_DATA_W-1:0] io_rdata = '0;
    logic [NUM_IO-1:0] io_ready = '0;

    logic                 memory_enable;
    logic [3:0]           memory_byte_en;
    logic [31:0]          memory_write_data;
    logic [NUM_IO-1:0]    io_sel;
    logic                 io_rd, io_wr;
    logic [IO_DATA_W-1:0] io_write_data;
    logic [31:0]          read_data;
    logic                 stall, bus_error;

    always #5 clock = ~clock;

    memio_bridge #(
        .NUM_IO(NUM_IO), .IO_BASE(IO_BASE), .IO_STRIDE(IO_STRIDE),
        .IO_DATA_W(IO_DATA_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock(clock), .reset(reset), .Address(address),
        .Memory_read(mem_read), .Memory_write(mem_write),
        .IO_read(io_read), .IO_write(io_write),
        .Memory_sign(mem_sign), .Memory_data_width(mem_width),
        .Write_data_in(wdata_in), .Memory_read_data(mem_rdata),
        .Memory_enable(memory_enable), .Memory_byte_en(memory_byte_en),
        .Memory_write_data(memory_write_data),
        .IO_read_data(io_rdata), .IO_ready(io_ready), .IO_sel(io_sel),
        .IO_rd(io_rd), .IO_wr(io_wr), .IO_write_data(io_write_data),
        .Read_data(read_data), .Stall(stall), .Bus_error(bus_error)
    );

    // Physical RAM driven by the DUT's strobes; the model keeps its own copy.
    logic [31:0] phys_ram [64];
    logic [31:0] init_ram [64];
    logic [31:0] model_ram [64];
    logic        ram_load = 1'b0;

    function automatic logic [31:0] mergeBytes(input logic [31:0] old, input logic [31:0] nw,
                                               input logic [3:0] en);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (en[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    assign mem_rdata = phys_ram[address[7:2]];

    always @(posedge clock) begin
        if (ram_load) phys_ram <= init_ram;
        else if (memory_enable) phys_ram[address[7:2]] <= mergeBytes(phys_ram[address[7:2]],
                                                                     memory_write_data, memory_byte_en);
    end

    typedef struct {
        logic        stall, men;
        logic [3:0]  be;
        logic [7:0]  sel;
        logic        rd, wr, berr;
        logic [31:0] rdata;
        logic        chk_wd;
        logic [31:0] wd;
        logic        chk_iowd;
        logic [15:0] iowd;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_rdata = '0;
    int          stall_cnt, sel_cnt, men_cnt, berr_cnt;
    logic [3:0]  last_be;
    logic [31:0] last_wd;
    logic [7:0]  last_sel;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        cmp("Stall", 32'(stall), 32'(e.stall));
        cmp("Memory_enable", 32'(memory_enable), 32'(e.men));
        cmp("Memory_byte_en", 32'(memory_byte_en), 32'(e.be));
        cmp("IO_sel", 32'(io_sel), 32'(e.sel));
        cmp("IO_rd", 32'(io_rd), 32'(e.rd));
        cmp("IO_wr", 32'(io_wr), 32'(e.wr));
        cmp("Bus_error", 32'(bus_error), 32'(e.berr));
        cmp("Read_data", read_data, e.rdata);
        if (e.chk_wd) cmp("Memory_write_data", memory_write_data, e.wd);
        if (e.chk_iowd) cmp("IO_write_data", 32'(io_write_data), 32'(e.iowd));
    endtask

    always @(negedge clock) begin
        if (reset && exp_q.size() > 0) checkOutput(exp_q.pop_front());
        if (stall) stall_cnt++;
        if (memory_enable) begin
            men_cnt++;
            last_be = memory_byte_en;
            last_wd = memory_write_data;
        end
        if (io_sel != '0) begin
            sel_cnt++;
            last_sel = io_sel;
        end
        if (bus_error) berr_cnt++;
    end

    function automatic exp_t baseExp(input logic st, input logic [31:0] rd);
        exp_t e;
        e = '{stall: st, men: 1'b0, be: 4'b0, sel: 8'b0, rd: 1'b0, wr: 1'b0, berr: 1'b0,
              rdata: rd, chk_wd: 1'b0, wd: 32'b0, chk_iowd: 1'b0, iowd: 16'b0};
        return e;
    endfunction

    // Model rules: lanes [a, a+size) are touched; stores repeat the low bytes.
    function automatic logic [3:0] laneMask(input logic [1:0] w, input logic [1:0] a);
        logic [3:0] m;
        int sz = 1 << w;
        for (int i = 0; i < 4; i++) m[i] = (i >= int'(a)) && (i < int'(a) + sz);
        return m;
    endfunction

    function automatic logic [31:0] storeImage(input logic [1:0] w, input logic [31:0] d);
        if (w == 2'b00) return (d & 32'hFF) * 32'h01010101;
        if (w == 2'b01) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] memLoad(input logic [1:0] w, input logic s,
                                            input logic [1:0] a, input logic [31:0] word);
        int sz = 1 << w;
        logic [31:0] mask, v;
        mask = (sz == 4) ? 32'hFFFFFFFF : (32'd1 << (8*sz)) - 32'd1;
        v = (word >> (8*int'(a))) & mask;
        if (s && sz < 4 && v[8*sz-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [31:0] ioLoad(input logic s, input logic [15:0] d);
        logic [31:0] v = {16'h0, d};
        if (s && d[15]) v = v | 32'hFFFF0000;
        return v;
    endfunction

    task automatic applyStimulus(input logic [3:0] strb, input logic [31:0] addr, input logic [1:0] w,
                                 input logic s, input logic [31:0] d, input int rdy_at,
                                 input logic [15:0] io_dat);
        logic        is_io, is_wr, legal, io_ok, done_ok;
        logic [31:0] off, res;
        logic [7:0]  onehot, noise;
        int          k, sz, idx;
        exp_t        e;
        is_io = strb[1] | strb[0];
        is_wr = strb[2] | strb[0];
        sz    = 1 << w;
        off   = addr - IO_BASE;
        io_ok = (off % IO_STRIDE == 0) && (off / IO_STRIDE < NUM_IO);
        k     = io_ok ? int'(off / IO_STRIDE) : 0;
        legal = ($countones(strb) == 1) && (w != 2'b11) && (addr % sz == 0) && (!is_io || io_ok);
        onehot = (legal && is_io) ? (8'd1 << k) : 8'd0;
        idx    = int'(addr[7:2]);

        @(posedge clock); #1;
        address = addr; mem_width = w; mem_sign = s; wdata_in = d;
        {mem_read, mem_write, io_read, io_write} = strb;
        io_ready = '0;
        for (int c = 0; c < NUM_IO; c++) io_rdata[c*IO_DATA_W +: IO_DATA_W] = 16'($urandom);
        if (onehot != 0) io_rdata[k*IO_DATA_W +: IO_DATA_W] = io_dat;
        exp_q.push_back(baseExp(1'b1, model_rdata));

        if (!legal) begin
            @(posedge clock); #1;
            e = baseExp(1'b0, 32'h0);
            e.berr = 1'b1;
            model_rdata = 32'h0;
            exp_q.push_back(e);
        end else if (!is_io) begin
            @(posedge clock); #1;
            e = baseExp(1'b1, model_rdata);
            e.men = 1'b1;
            if (is_wr) begin
                e.be = laneMask(w, addr[1:0]);
                e.chk_wd = 1'b1;
                e.wd = storeImage(w, d);
            end
            exp_q.push_back(e);
            if (is_wr) model_ram[idx] = mergeBytes(model_ram[idx], storeImage(w, d), laneMask(w, addr[1:0]));
            else model_rdata = memLoad(w, s, addr[1:0], model_ram[idx]);
            @(posedge clock); #1;
            exp_q.push_back(baseExp(1'b0, model_rdata));
        end else begin
            done_ok = 1'b0;
            for (int i = 1; i <= TIMEOUT + 1; i++) begin
                @(posedge clock); #1;
                noise = 8'($urandom) & ~onehot;
                io_ready = noise | ((i == rdy_at) ? onehot : 8'd0);
                e = baseExp(1'b1, model_rdata);
                e.sel = onehot; e.rd = strb[1]; e.wr = strb[0];
                e.chk_iowd = 1'b1; e.iowd = d[15:0];
                exp_q.push_back(e);
                if (i == rdy_at) begin
                    done_ok = 1'b1;
                    break;
                end
            end
            @(posedge clock); #1;
            io_ready = '0;
            if (done_ok) begin
                if (!is_wr) model_rdata = ioLoad(s, io_dat);
                exp_q.push_back(baseExp(1'b0, model_rdata));
            end else begin
                model_rdata = 32'h0;
                e = baseExp(1'b0, 32'h0);
                e.berr = 1'b1;
                exp_q.push_back(e);
            end
        end
        // Strobes are still high in DONE/ERR above; they must be ignored there.
        @(posedge clock); #1;
        {mem_read, mem_write, io_read, io_write} = 4'b0000;
        io_ready = '0;
        exp_q.push_back(baseExp(1'b0, model_rdata));
    endtask

    task automatic clearCounters();
        stall_cnt = 0; sel_cnt = 0; men_cnt = 0; berr_cnt = 0;
        last_be = '0; last_wd = '0; last_sel = '0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [3:0]  strb;
        logic [31:0] addr;
        logic [1:0]  w;

        for (int i = 0; i < 64; i++) begin
            init_ram[i]  = $urandom;
            model_ram[i] = init_ram[i];
        end
        ram_load = 1'b1;
        @(posedge clock); #1;
        ram_load = 1'b0;
        @(negedge clock);
        cmp("reset_Stall", 32'(stall), 32'h0);
        cmp("reset_Read_data", read_data, 32'h0);
        cmp("reset_IO_sel", 32'(io_sel), 32'h0);
        cmp("reset_Memory_enable", 32'(memory_enable), 32'h0);
        reset = 1'b1;

        clearCounters();
        applyStimulus(MW, 32'h100, 2'b10, 1'b0, 32'h12345678, NEVER, 16'h0);
        cmp("sw_byte_en", 32'(last_be), 32'hF);
        cmp("sw_stall_cycles", 32'(stall_cnt), 32'd2);

        clearCounters();
        applyStimulus(MR, 32'h103, 2'b00, 1'b1, 32'h0, NEVER, 16'h0);
        cmp("lb_result", read_data, 32'h00000012);
        cmp("lb_stall_cycles", 32'(stall_cnt), 32'd2);

        applyStimulus(MW, 32'h100, 2'b10, 1'b0, 32'h80FF0000, NEVER, 16'h0);
        applyStimulus(MR, 32'h102, 2'b01, 1'b1, 32'h0, NEVER, 16'h0);
        cmp("lh_result", read_data, 32'hFFFF80FF);

        clearCounters();
        applyStimulus(MW, 32'h101, 2'b00, 1'b0, 32'h000000AB, NEVER, 16'h0);
        cmp("sb_byte_en", 32'(last_be), 32'h2);
        cmp("sb_write_data", last_wd, 32'hABABABAB);

        clearCounters();
        applyStimulus(IR, 32'hFFFFFC30, 2'b10, 1'b0, 32'h0, 4, 16'h8001);
        cmp("io_sel_value", 32'(last_sel), 32'h08);
        cmp("io_sel_cycles", 32'(sel_cnt), 32'd4);
        cmp("io_rd_zext", read_data, 32'h00008001);
        applyStimulus(IR, 32'hFFFFFC30, 2'b10, 1'b1, 32'h0, 4, 16'h8001);
        cmp("io_rd_sext", read_data, 32'hFFFF8001);

        clearCounters();
        applyStimulus(IW, 32'hFFFFFC50, 2'b10, 1'b0, 32'h5555, NEVER, 16'h0);
        cmp("timeout_io_cycles", 32'(sel_cnt), 32'(TIMEOUT + 1));
        cmp("timeout_berr_pulses", 32'(berr_cnt), 32'd1);
        cmp("timeout_read_data", read_data, 32'h0);

        clearCounters();
        applyStimulus(MR, 32'h102, 2'b10, 1'b0, 32'h0, NEVER, 16'h0);
        applyStimulus(IR, 32'hFFFFFC04, 2'b10, 1'b0, 32'h0, 1, 16'h0);
        applyStimulus(IR, 32'hFFFFFC80, 2'b10, 1'b0, 32'h0, 1, 16'h0);
        applyStimulus(MR | IR, 32'h100, 2'b10, 1'b0, 32'h0, 1, 16'h0);
        cmp("illegal_berr_pulses", 32'(berr_cnt), 32'd4);
        cmp("illegal_mem_enables", 32'(men_cnt), 32'd0);
        cmp("illegal_io_selects", 32'(sel_cnt), 32'd0);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 19) == 0) strb = 4'($urandom_range(1, 15));
            else strb = 4'b0001 << $urandom_range(0, 3);
            w = ($urandom_range(0, 19) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            if (strb[1] | strb[0]) begin
                addr = IO_BASE + 32'($urandom_range(0, 9)) * IO_STRIDE;
                if ($urandom_range(0, 9) == 0) addr = addr + 32'($urandom_range(1, 15));
            end else begin
                addr = 32'($urandom_range(0, 255));
                if ($urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << w) - 32'd1);
            end
            applyStimulus(strb, addr, w, 1'($urandom), $urandom, $urandom_range(1, 20),
                          16'($urandom));
        end

        // Abort an IO access mid-wait with an asynchronous reset.
        @(posedge clock); #1;
        address = 32'hFFFFFC20; mem_width = 2'b10; wdata_in = 32'h1234; io_read = 1'b1;
        io_ready = '0;
        repeat (3) @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        cmp("abort_Stall", 32'(stall), 32'h0);
        cmp("abort_IO_sel", 32'(io_sel), 32'h0);
        cmp("abort_IO_rd", 32'(io_rd), 32'h0);
        cmp("abort_Read_data", read_data, 32'h0);
        cmp("abort_IO_write_data", 32'(io_write_data), 32'h0);
        cmp("abort_Memory_write_data", memory_write_data, 32'h0);
        io_read = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        model_rdata = 32'h0;
        clearCounters();
        applyStimulus(MR, 32'h104, 2'b10, 1'b0, 32'h0, NEVER, 16'h0);
        cmp("post_reset_lw", read_data, model_ram[1]);
        cmp("post_reset_stall_cycles", 32'(stall_cnt), 32'd2);

        repeat (2) @(posedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
